// File: rtl/sa_pkg.sv
// Shared types and helpers for the output-stationary systolic array front end.
package sa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        FLUSH,
        DONE
    } feeder_state_t;

    // Cycles of zero-feed needed so the far-corner PE has absorbed the last real beat.
    function automatic int unsigned flush_len(input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned pe_lat);
        return (rows - 1) + (cols - 1) + pe_lat;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Enabled shift register of DEPTH stages; q is the value pushed DEPTH advances ago.
module skew_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/os_skew_feeder.sv
// Tile sequencer and diagonal skew for the left/top edges of the output-stationary array.
module os_skew_feeder
    import sa_pkg::*;
#(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int PE_LAT  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W-1:0]         k_len,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*WIDTH_A-1:0]  act_in,
    input  logic [COLS*WIDTH_B-1:0]  wei_in,
    output logic [ROWS*WIDTH_A-1:0]  act_out,
    output logic [COLS*WIDTH_B-1:0]  wei_out,
    output logic                     pipeline_en,
    output logic                     reg_clear
);

    localparam int unsigned FLUSH_LEN = flush_len(ROWS, COLS, PE_LAT);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);

    if (longint'(FLUSH_LEN) >= (longint'(1) << CNT_W)) begin : g_flush_len_chk
        $error("os_skew_feeder: FLUSH_LEN does not fit in CNT_W bits");
    end

    feeder_state_t    state;
    logic [CNT_W-1:0] k_len_q;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             streaming;
    logic             flushing;

    assign streaming   = (state == STREAM);
    assign flushing    = (state == FLUSH);
    // Stalls in STREAM must freeze the whole array, so the enable follows in_valid directly.
    assign pipeline_en = (streaming && in_valid) || flushing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_len_q   <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            reg_clear <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k_len_q   <= k_len;
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        reg_clear <= 1'b1;
                    end
                end
                CLEAR: begin
                    reg_clear <= 1'b0;
                    beat_cnt  <= '0;
                    flush_cnt <= '0;
                    if (k_len_q != '0) begin
                        state    <= STREAM;
                        in_ready <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (beat_cnt == k_len_q - CNT_W'(1)) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + CNT_W'(1);
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    in_ready  <= 1'b0;
                    reg_clear <= 1'b0;
                end
            endcase
        end
    end

    // Lane i is delayed i+1 advances; zeros are fed outside STREAM so FLUSH drains the lines.
    for (genvar r = 0; r < ROWS; r++) begin : g_act
        logic [WIDTH_A-1:0] d;
        assign d = streaming ? act_in[r*WIDTH_A +: WIDTH_A] : '0;
        skew_line #(.WIDTH(WIDTH_A), .DEPTH(r + 1)) u_line (
            .clk (clk),
            .rst (rst),
            .en  (pipeline_en),
            .d   (d),
            .q   (act_out[r*WIDTH_A +: WIDTH_A])
        );
    end

    for (genvar c = 0; c < COLS; c++) begin : g_wei
        logic [WIDTH_B-1:0] d;
        assign d = streaming ? wei_in[c*WIDTH_B +: WIDTH_B] : '0;
        skew_line #(.WIDTH(WIDTH_B), .DEPTH(c + 1)) u_line (
            .clk (clk),
            .rst (rst),
            .en  (pipeline_en),
            .d   (d),
            .q   (wei_out[c*WIDTH_B +: WIDTH_B])
        );
    end

endmodule

// File: tb/tb_os_skew_feeder.sv
// Randomized tiles against a timeline/queue reference model, plus directed latency checks.
module tb_os_skew_feeder;

    localparam int W     = 16;
    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int CNT_W = 16;
    localparam int FLEN  = 10;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [CNT_W-1:0]      k_len;
    logic                  busy, done, in_valid, in_ready, pipeline_en, reg_clear;
    logic [ROWS*W-1:0]     act_in, act_out;
    logic [COLS*W-1:0]     wei_in, wei_out;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    os_skew_feeder #(
        .WIDTH_A(W), .WIDTH_B(W), .ROWS(ROWS), .COLS(COLS), .PE_LAT(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .act_in(act_in), .wei_in(wei_in),
        .act_out(act_out), .wei_out(wei_out), .pipeline_en(pipeline_en), .reg_clear(reg_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Reference model: tile timeline as plain counters, skew lines as a history of advances.
    bit          m_busy, m_clear, m_done;
    int          m_klen, m_beats_left, m_flush_left;
    logic [31:0] ahist[$];
    logic [31:0] whist[$];

    initial begin
        bit          strm, e_pe;
        logic [31:0] ea, ew;
        int          idx;
        m_busy = 0; m_clear = 0; m_done = 0; m_klen = 0; m_beats_left = 0; m_flush_left = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            strm = m_busy && !m_clear && !m_done && m_beats_left > 0;
            e_pe = strm ? in_valid : (m_flush_left > 0);
            ea = '0; ew = '0;
            for (int r = 0; r < ROWS; r++) begin
                idx = ahist.size() - 1 - r;
                if (idx >= 0) ea[r*W +: W] = ahist[idx][r*W +: W];
                idx = whist.size() - 1 - r;
                if (idx >= 0) ew[r*W +: W] = whist[idx][r*W +: W];
            end
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("reg_clear", 64'(reg_clear), 64'(m_clear));
            chk("in_ready", 64'(in_ready), 64'(strm));
            chk("pipeline_en", 64'(pipeline_en), 64'(e_pe));
            chk("act_out", 64'(act_out), 64'(ea));
            chk("wei_out", 64'(wei_out), 64'(ew));
            if (rst) begin
                m_busy = 0; m_clear = 0; m_done = 0; m_beats_left = 0; m_flush_left = 0;
                ahist.delete(); whist.delete();
            end else begin
                if (e_pe) begin
                    ahist.push_back(strm ? act_in : '0);
                    whist.push_back(strm ? wei_in : '0);
                    if (ahist.size() > 4) begin void'(ahist.pop_front()); void'(whist.pop_front()); end
                end
                if (!m_busy) begin
                    if (start) begin m_busy = 1; m_clear = 1; m_klen = int'(k_len); end
                end else if (m_clear) begin
                    m_clear = 0;
                    if (m_klen == 0) m_done = 1; else m_beats_left = m_klen;
                end else if (strm) begin
                    if (in_valid) begin
                        m_beats_left--;
                        if (m_beats_left == 0) m_flush_left = FLEN;
                    end
                end else if (m_flush_left > 0) begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_done = 1;
                end else if (m_done) begin
                    m_done = 0; m_busy = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // mode 0: fixed data, valid high; 1: random data; 2: random data and random valid
    task automatic run_tile(input int klen, input int stall_at, input int stall_len, input int mode,
                            input logic [31:0] a, input logic [31:0] w, input bit poke,
                            input bit zchk, output int lat);
        int s, sent, stall_left, fa, nclr, nrdy, npe, budget;
        bit fin, poked;
        s = cyc; sent = 0; stall_left = stall_len; fa = -1; nclr = 0; nrdy = 0; npe = 0;
        budget = 0; fin = 0; poked = 0; lat = -1;
        start = 1; k_len = CNT_W'(klen); in_valid = (mode != 2 && klen == 0);
        tick(1);
        start = 0;
        while (!fin && budget < 300) begin
            if (sent < klen) begin
                if (sent == stall_at && stall_left > 0) begin in_valid = 0; stall_left--; end
                else in_valid = (mode == 2) ? 1'($urandom % 2) : 1'b1;
                act_in = (mode == 0) ? a : $urandom;
                wei_in = (mode == 0) ? w : $urandom;
            end else begin
                in_valid = (klen == 0);
                act_in = $urandom; wei_in = $urandom;
            end
            start = poke && !poked && klen > 0 && sent >= klen;
            if (start) poked = 1;
            @(negedge clk);
            if (reg_clear) nclr++;
            if (in_ready) nrdy++;
            if (pipeline_en) npe++;
            if (in_valid && in_ready) begin sent++; if (fa < 0) fa = cyc; end
            if (mode == 0 && fa >= 0 && cyc == fa + 1) begin
                chk("lit_act_lane0", 64'(act_out[0 +: W]), 64'(a[0 +: W]));
                chk("lit_wei_lane0", 64'(wei_out[0 +: W]), 64'(w[0 +: W]));
            end
            if (mode == 0 && stall_len == 0 && klen >= 2 && fa >= 0 && cyc == fa + 2) begin
                chk("lit_act_lane1", 64'(act_out[W +: W]), 64'(a[W +: W]));
                chk("lit_wei_lane1", 64'(wei_out[W +: W]), 64'(w[W +: W]));
            end
            if (done) begin
                lat = cyc - s; fin = 1;
                if (zchk) begin
                    chk("flush_act_zero", 64'(act_out), 64'd0);
                    chk("flush_wei_zero", 64'(wei_out), 64'd0);
                end
            end
            @(posedge clk); #1;
            budget++;
        end
        start = 0; in_valid = 0;
        chk("tile_finished", 64'(fin), 64'd1);
        chk("clear_one_cycle", 64'(nclr), 64'd1);
        if (klen == 0) begin
            chk("k0_no_ready", 64'(nrdy), 64'd0);
            chk("k0_no_pe", 64'(npe), 64'd0);
        end
    endtask

    initial begin
        int lat;
        rst = 1; start = 0; k_len = '0; in_valid = 0; act_in = '0; wei_in = '0;
        tick(2);
        rst = 0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_act", 64'(act_out), 64'd0);
        tick(1);

        // reset mid-stream after two accepted beats
        start = 1; k_len = 4; tick(1);
        start = 0; in_valid = 1; act_in = $urandom; wei_in = $urandom; tick(1);
        act_in = $urandom; tick(1);
        act_in = $urandom; tick(1);
        rst = 1; in_valid = 0; tick(1);
        rst = 0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_act", 64'(act_out), 64'd0);
        chk("midrst_wei", 64'(wei_out), 64'd0);
        tick(3);

        run_tile(3, -1, 0, 0, {16'd2, 16'd1}, {16'd4, 16'd3}, 0, 0, lat);
        chk("basic_latency", 64'(lat), 64'd15);
        tick(2);
        run_tile(2, -1, 0, 1, '0, '0, 0, 0, lat);
        chk("k2_latency", 64'(lat), 64'd14);
        tick(2);
        run_tile(2, 1, 3, 0, {16'd9, 16'd8}, {16'd6, 16'd5}, 0, 0, lat);
        chk("stall_latency", 64'(lat), 64'd17);
        tick(2);
        run_tile(0, -1, 0, 1, '0, '0, 0, 0, lat);
        chk("k0_latency", 64'(lat), 64'd2);
        tick(2);
        run_tile(3, -1, 0, 1, '0, '0, 1, 0, lat);
        chk("poke_latency", 64'(lat), 64'd15);
        tick(3);
        run_tile(1, -1, 0, 0, {16'd5, 16'd5}, {16'd7, 16'd7}, 0, 1, lat);
        chk("k1_latency", 64'(lat), 64'd13);
        tick(2);
        for (int t = 0; t < 10; t++) begin
            run_tile(int'($urandom_range(1, 6)), -1, 0, 2, '0, '0, 1'($urandom % 2), 1, lat);
            tick(int'($urandom_range(0, 3)));
        end
        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
